// File: rtl/alu_pkg.sv
// Shared encodings for the sail-core ALU: RV32M divide ops, divider FSM states and special-case constants.
`timescale 1ns/1ps
package alu_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_CALC  = 2'b01;
  localparam logic [1:0] S_FIXUP = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  function automatic logic [31:0] twos_neg(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/seq_divider_addsub.sv
// DSP-style adder/subtractor; with i_is_sub=1 computes i_a - i_b and o_cout=1 means no borrow.
`timescale 1ns/1ps
module seq_divider_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_is_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH-1:0] w_b_eff;

  assign w_b_eff = i_is_sub ? ~i_b : i_b;
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_is_sub};

endmodule

// File: rtl/seq_divider.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring division, one quotient bit per clock.
// state   | meaning
// S_IDLE  | waiting for start; special cases resolve here directly to S_DONE
// S_CALC  | one shift/trial-subtract per edge, 32 edges
// S_FIXUP | apply signs, select quotient or remainder into result
// S_DONE  | one-cycle done pulse, then back to S_IDLE
`timescale 1ns/1ps
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_op_rem;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_result;

  logic             w_signed_op;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic             w_div_zero;
  logic             w_overflow;
  logic [WIDTH:0]   w_rs;
  logic [WIDTH-1:0] w_diff;
  logic             w_cout;
  logic             w_trial_ok;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_signed_op = ~op[0];
  assign w_dvd_neg   = w_signed_op & dividend[WIDTH-1];
  assign w_dvs_neg   = w_signed_op & divisor[WIDTH-1];
  assign w_div_zero  = (divisor == '0);
  assign w_overflow  = w_signed_op && (dividend == INT_MIN) && (divisor == '1);

  // Shifted partial remainder is 33 bits; the low 32 go through the subtractor and the
  // top bit is folded in here: the trial is non-negative if that bit is set or no borrow.
  assign w_rs = {r_rem, r_quo[WIDTH-1]};

  seq_divider_addsub #(.WIDTH(WIDTH)) u_trial (
    .i_a      (w_rs[WIDTH-1:0]),
    .i_b      (r_dvs),
    .i_is_sub (1'b1),
    .o_sum    (w_diff),
    .o_cout   (w_cout)
  );

  assign w_trial_ok = w_rs[WIDTH] | w_cout;
  assign w_q_fix    = r_sign_q ? twos_neg(r_quo) : r_quo;
  assign w_r_fix    = r_sign_r ? twos_neg(r_rem) : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_op_rem <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op_rem <= op[1];
            if (w_div_zero) begin
              r_result <= op[1] ? dividend : DIV_ZERO_Q;
              r_state  <= S_DONE;
            end else if (w_overflow) begin
              r_result <= op[1] ? '0 : INT_MIN;
              r_state  <= S_DONE;
            end else begin
              r_cnt    <= CNT_W'(WIDTH - 1);
              r_rem    <= '0;
              r_quo    <= w_dvd_neg ? twos_neg(dividend) : dividend;
              r_dvs    <= w_dvs_neg ? twos_neg(divisor) : divisor;
              r_sign_q <= w_dvd_neg ^ w_dvs_neg;
              r_sign_r <= w_dvd_neg;
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_trial_ok ? w_diff : w_rs[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_trial_ok};
          if (r_cnt == '0) begin
            r_state <= S_FIXUP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FIXUP: begin
          r_result <= r_op_rem ? w_r_fix : w_q_fix;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed RV32M corner cases plus randomized operations.
`timescale 1ns/1ps
module tb_seq_divider;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          start_cyc;
    int          exp_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc;
  int          total;
  int          bad;
  logic [31:0] last_res;

  seq_divider #(.WIDTH(32), .CNT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got cyc=%0d want completion", cyc);
    $fatal(1);
  end

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  function automatic int latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Monitor: busy window, result stability and done/result/latency against the queue head.
  initial begin
    logic exp_busy;
    logic may_change;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        exp_busy = (sb_q.size() > 0) && (cyc > sb_q[0].start_cyc) && (cyc <= sb_q[0].exp_cyc);
        total++;
        if (busy !== exp_busy) begin
          bad++;
          $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
        end
        may_change = (sb_q.size() > 0) && ((cyc == sb_q[0].exp_cyc) || (cyc == sb_q[0].exp_cyc - 1));
        if (!may_change) begin
          total++;
          if (result !== last_res) begin
            bad++;
            $display("FAIL result_hold cyc=%0d got=%h want=%h", cyc, result, last_res);
          end
        end
        if (done === 1'b1) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done cyc=%0d got=1 want=0 result=%h", cyc, result);
          end else begin
            e = sb_q.pop_front();
            total++;
            if (result !== e.res) begin
              bad++;
              $display("FAIL result cyc=%0d got=%h want=%h", cyc, result, e.res);
            end
            total++;
            if (cyc != e.exp_cyc) begin
              bad++;
              $display("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, e.exp_cyc);
            end
          end
        end
      end
      last_res = result;
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout cyc=%0d got=no_done want=done pending=%0d", cyc, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, output int s);
    exp_t e;
    @(negedge clk);
    s           = cyc;
    e.res       = exp_res;
    e.start_cyc = cyc;
    e.exp_cyc   = cyc + latency(o, a, b);
    sb_q.push_back(e);
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    op       = 2'($urandom_range(0, 3));
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res);
    int s;
    issue(o, a, b, exp_res, s);
    drain();
  endtask

  initial begin
    int s;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 2'b00;
    dividend = '0;
    divisor  = '0;
    last_res = '0;

    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      bad++;
      $display("FAIL reset_state got busy=%b done=%b result=%h want 0 0 00000000", busy, done, result);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(OP_DIVU, 32'd100, 32'd7, 32'h0000_000E);
    run_op(OP_REMU, 32'd100, 32'd7, 32'h0000_0002);
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op(OP_REMU, 32'd5, 32'd0, 32'h0000_0005);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // Starts while busy (mid-CALC and in DONE) must be ignored.
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, s);
    while (cyc < s + 5) @(negedge clk);
    start    = 1'b1;
    op       = OP_DIV;
    dividend = 32'd123;
    divisor  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 34) @(negedge clk);
    start    = 1'b1;
    op       = OP_REMU;
    dividend = 32'd77;
    divisor  = 32'd0;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F);

    // Asynchronous reset in the middle of a DIV.
    issue(OP_DIV, 32'hFFFF_FC18, 32'd7, model(OP_DIV, 32'hFFFF_FC18, 32'd7), s);
    while (cyc < s + 10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      bad++;
      $display("FAIL async_reset got busy=%b done=%b result=%h want 0 0 00000000", busy, done, result);
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(OP_DIVU, 32'd100, 32'd7, 32'h0000_000E);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        3: begin
          ra = 32'h8000_0000;
          rb = $urandom;
        end
        4:       rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, model(ro, ra, rb));
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
